// File: rtl/piso_serializer.sv
// piso_serializer
//
// Parallel-in / serial-out converter with a valid/ready load handshake.
// An accepted word is streamed one bit per clock. The first bit appears on
// `out` on the cycle after the handshake. `frame_start` marks the first bit
// and `done` marks the last bit. A new word may be accepted in the last-bit
// cycle, so consecutive words stream with no idle gap.
//
// Build option:
//   PISO_MSB_FIRST_EN  when defined, emit load_data[WIDTH-1] first;
//                      otherwise emit load_data[0] first.
//
// Parameters:
//   WIDTH        bits per parallel word (2..32)
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   load_valid   parallel word offered on load_data
//   load_data    parallel word to serialise
//   load_ready   word can be accepted this cycle (combinational)
//   out          serial data bit (registered)
//   out_valid    out carries a valid bit (registered)
//   frame_start  high with the first bit of each word (registered)
//   done         high with the last bit of each word (registered)

module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] PenultIdx = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic             out_q, out_d;
  logic             outValid_q, outValid_d;
  logic             frameStart_q, frameStart_d;
  logic             done_q, done_d;

  logic             handshake;
  logic             loadBit;
  logic [WIDTH-1:0] loadRest;
  logic             nextBit;
  logic [WIDTH-1:0] nextRest;

  // The first bit of a word goes straight into the output register at the
  // handshake. The shift register therefore holds the remaining bits,
  // already pre-shifted.
`ifdef PISO_MSB_FIRST_EN
  assign loadBit  = load_data[WIDTH-1];
  assign loadRest = load_data << 1;
  assign nextBit  = shift_q[WIDTH-1];
  assign nextRest = shift_q << 1;
`else
  assign loadBit  = load_data[0];
  assign loadRest = load_data >> 1;
  assign nextBit  = shift_q[0];
  assign nextRest = shift_q >> 1;
`endif

  // The registered `done` flag is high exactly in the last-bit cycle. That
  // is the only SHIFT cycle in which the next word may be taken.
  assign load_ready = (state_q == IDLE) || done_q;
  assign handshake  = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitCnt_d     = bitCnt_q;
    out_d        = 1'b0;
    outValid_d   = 1'b0;
    frameStart_d = 1'b0;
    done_d       = 1'b0;

    if (handshake) begin
      state_d      = SHIFT;
      shift_d      = loadRest;
      bitCnt_d     = '0;
      out_d        = loadBit;
      outValid_d   = 1'b1;
      frameStart_d = 1'b1;
    end else if (state_q == SHIFT) begin
      if (done_q) begin
        state_d  = IDLE;
        bitCnt_d = '0;
      end else begin
        // The counter stops at WIDTH-1. The cycle that reaches it raises
        // done, which ends the word on the following edge.
        shift_d    = nextRest;
        bitCnt_d   = bitCnt_q + 1'b1;
        out_d      = nextBit;
        outValid_d = 1'b1;
        done_d     = (bitCnt_q == PenultIdx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      out_q        <= 1'b0;
      outValid_q   <= 1'b0;
      frameStart_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitCnt_q     <= bitCnt_d;
      out_q        <= out_d;
      outValid_q   <= outValid_d;
      frameStart_q <= frameStart_d;
      done_q       <= done_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = outValid_q;
  assign frame_start = frameStart_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
//
// Directed bench for piso_serializer.
// - dut is an 8-bit instance, checked every cycle against a queue of
//   expected bits.
// - dut2 is a 2-bit instance that covers the minimum width.
// Honours PISO_MSB_FIRST_EN in the same way as the design.

module tb_piso_serializer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         loadValid;
  logic [W-1:0] loadData;
  logic         loadReady;
  logic         outBit;
  logic         outValid;
  logic         frameStart;
  logic         done;

  logic         loadValid2;
  logic [1:0]   loadData2;
  logic         loadReady2;
  logic         outBit2;
  logic         outValid2;
  logic         frameStart2;
  logic         done2;

  typedef struct packed {
    logic bitv;
    logic fs;
    logic dn;
  } exp_t;

  exp_t sbQueue[$];

  int   checks = 0;
  int   failures = 0;
  logic expReady;
  int   hsCount;
  int   cycleNum = 0;
  int   doneCount;
  int   lastDoneCycle;
  int   doneGap;
  int   validRun;
  int   maxRun;
  logic [7:0] streamVec;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_valid  (loadValid),
    .load_data   (loadData),
    .load_ready  (loadReady),
    .out         (outBit),
    .out_valid   (outValid),
    .frame_start (frameStart),
    .done        (done)
  );

  piso_serializer #(.WIDTH(2)) dut2 (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_valid  (loadValid2),
    .load_data   (loadData2),
    .load_ready  (loadReady2),
    .out         (outBit2),
    .out_valid   (outValid2),
    .frame_start (frameStart2),
    .done        (done2)
  );

  // Bit of `word` expected at position idx of the serial stream.
  function automatic logic expBit(input logic [31:0] word, input int idx, input int width);
`ifdef PISO_MSB_FIRST_EN
    return word[width-1-idx];
`else
    return word[idx];
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNum, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [W-1:0] word);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.bitv = expBit(32'(word), i, W);
      e.fs   = (i == 0);
      e.dn   = (i == W - 1);
      sbQueue.push_back(e);
    end
  endtask

  // Advance one clock, then check the 8-bit instance #1 after the edge.
  task automatic applyStimulus();
    logic hs;
    exp_t e;
    hs = loadValid && expReady;
    @(posedge clock);
    cycleNum++;
    if (hs) begin
      pushWord(loadData);
      hsCount++;
    end
    #1;
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput("out_valid", 32'(outValid), 32'd1);
      checkOutput("out", 32'(outBit), 32'(e.bitv));
      checkOutput("frame_start", 32'(frameStart), 32'(e.fs));
      checkOutput("done", 32'(done), 32'(e.dn));
      expReady = e.dn;
    end else begin
      checkOutput("idle_out_valid", 32'(outValid), 32'd0);
      checkOutput("idle_out", 32'(outBit), 32'd0);
      checkOutput("idle_frame_start", 32'(frameStart), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
      expReady = 1'b1;
    end
    checkOutput("load_ready", 32'(loadReady), 32'(expReady));
    if (outValid === 1'b1) begin
      streamVec = {streamVec[6:0], outBit};
      validRun++;
      if (validRun > maxRun) maxRun = validRun;
    end else begin
      validRun = 0;
    end
    if (done === 1'b1) begin
      doneCount++;
      doneGap = cycleNum - lastDoneCycle;
      lastDoneCycle = cycleNum;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    loadValid  = 1'b0;
    loadData   = '0;
    loadValid2 = 1'b0;
    loadData2  = '0;
    expReady   = 1'b1;
    hsCount    = 0;
    doneCount  = 0;
    lastDoneCycle = 0;
    doneGap    = 0;
    validRun   = 0;
    maxRun     = 0;
    streamVec  = '0;

    // Reset state
    #2;
    checkOutput("rst_out", 32'(outBit), 32'd0);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_frame_start", 32'(frameStart), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_load_ready", 32'(loadReady), 32'd1);
    checkOutput("rst2_out_valid", 32'(outValid2), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    applyStimulus();
    applyStimulus();

    // 8'hA5 -> stream 1,0,1,0,0,1,0,1 in either bit order
    $display("[TB] word A5");
    streamVec = '0;
    loadValid = 1'b1;
    loadData  = 8'hA5;
    applyStimulus();
    loadValid = 1'b0;
    loadData  = 8'h00;
    repeat (8) applyStimulus();
    checkOutput("stream_A5", 32'(streamVec), 32'h000000A5);

    // 8'h01
    $display("[TB] word 01");
    streamVec = '0;
    loadValid = 1'b1;
    loadData  = 8'h01;
    applyStimulus();
    loadValid = 1'b0;
    repeat (8) applyStimulus();
`ifdef PISO_MSB_FIRST_EN
    checkOutput("stream_01", 32'(streamVec), 32'h00000001);
`else
    checkOutput("stream_01", 32'(streamVec), 32'h00000080);
`endif

    // Back-to-back: load_valid held, FF then 00
    $display("[TB] back-to-back");
    hsCount   = 0;
    doneCount = 0;
    maxRun    = 0;
    validRun  = 0;
    loadValid = 1'b1;
    loadData  = 8'hFF;
    applyStimulus();
    loadData  = 8'h00;
    for (int k = 0; k < 20 && hsCount < 2; k++) applyStimulus();
    loadValid = 1'b0;
    checkOutput("b2b_handshakes", 32'(hsCount), 32'd2);
    for (int k = 0; k < 20 && sbQueue.size() > 0; k++) applyStimulus();
    applyStimulus();
    checkOutput("b2b_drained", 32'(sbQueue.size()), 32'd0);
    checkOutput("b2b_valid_run", 32'(maxRun), 32'd16);
    checkOutput("b2b_done_count", 32'(doneCount), 32'd2);
    checkOutput("b2b_done_gap", 32'(doneGap), 32'd8);

    // load_data changes while busy must not disturb the word in flight
    $display("[TB] busy changes");
    streamVec = '0;
    loadValid = 1'b1;
    loadData  = 8'h3C;
    applyStimulus();
    for (int k = 0; k < 6; k++) begin
      loadData = 8'($urandom);
      applyStimulus();
    end
    loadValid = 1'b0;
    applyStimulus();
    applyStimulus();
`ifdef PISO_MSB_FIRST_EN
    checkOutput("stream_3C", 32'(streamVec), 32'h0000003C);
`else
    checkOutput("stream_3C", 32'(streamVec), 32'h0000003C);
`endif

    // Asynchronous reset in the middle of a word
    $display("[TB] reset mid-word");
    loadValid = 1'b1;
    loadData  = 8'hC3;
    applyStimulus();
    loadValid = 1'b0;
    repeat (3) applyStimulus();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_out", 32'(outBit), 32'd0);
    checkOutput("async_rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("async_rst_frame_start", 32'(frameStart), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_load_ready", 32'(loadReady), 32'd1);
    sbQueue.delete();
    expReady = 1'b1;
    applyStimulus();
    #2 reset_n = 1'b1;
    applyStimulus();
    applyStimulus();
    loadValid = 1'b1;
    loadData  = 8'h5A;
    applyStimulus();
    loadValid = 1'b0;
    repeat (8) applyStimulus();

    // Minimum width on the 2-bit instance: 2'b10
    $display("[TB] width 2");
    checkOutput("w2_ready_idle", 32'(loadReady2), 32'd1);
    loadValid2 = 1'b1;
    loadData2  = 2'b10;
    applyStimulus();
    loadValid2 = 1'b0;
    checkOutput("w2_b0_valid", 32'(outValid2), 32'd1);
    checkOutput("w2_b0_out", 32'(outBit2), 32'(expBit(32'h2, 0, 2)));
    checkOutput("w2_b0_fs", 32'(frameStart2), 32'd1);
    checkOutput("w2_b0_done", 32'(done2), 32'd0);
    checkOutput("w2_b0_ready", 32'(loadReady2), 32'd0);
    applyStimulus();
    checkOutput("w2_b1_valid", 32'(outValid2), 32'd1);
    checkOutput("w2_b1_out", 32'(outBit2), 32'(expBit(32'h2, 1, 2)));
    checkOutput("w2_b1_fs", 32'(frameStart2), 32'd0);
    checkOutput("w2_b1_done", 32'(done2), 32'd1);
    checkOutput("w2_b1_ready", 32'(loadReady2), 32'd1);
    applyStimulus();
    checkOutput("w2_idle_valid", 32'(outValid2), 32'd0);
    checkOutput("w2_idle_out", 32'(outBit2), 32'd0);
    checkOutput("w2_idle_done", 32'(done2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
